div_arbiter: RTL and testbench

//   Shares one long-division unit (control + datapath) between NREQ requesters.

---
 rtl/div_arbiter.sv | 163 ++++++++++++++++
 tb/tb_div_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end sharing one long-division unit between
// NREQ requesters. One operand pair is accepted per grant, the divider's
// start/done handshake is sequenced with a watchdog, and the result is
// returned tagged with the requester index.
module div_arbiter #(
    parameter int SIZE    = 32,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*SIZE-1:0] req_dividend,
    input  logic [NREQ*SIZE-1:0] req_divisor,
    output logic                 div_start,
    output logic [SIZE-1:0]      div_dividend,
    output logic [SIZE-1:0]      div_divisor,
    input  logic                 div_done,
    input  logic                 div_error,
    input  logic [SIZE-1:0]      div_quotient,
    input  logic [SIZE-1:0]      div_remainder,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [SIZE-1:0]      rsp_quotient,
    output logic [SIZE-1:0]      rsp_remainder,
    output logic                 rsp_error
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [SIZE-1:0] dvd_q, dvd_d;
    logic [SIZE-1:0] dvs_q, dvs_d;
    logic            start_q, start_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic            rv_q, rv_d;
    logic [SIZE-1:0] rq_q, rq_d;
    logic [SIZE-1:0] rr_q, rr_d;
    logic            re_q, re_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_idx;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Accept is offered only while idle, so requests seen in other states are ignored.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found)
            req_ready = NREQ'(1) << gnt_idx;
    end

    // Next-state and datapath update for the issue/wait/respond sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        start_d = 1'b0;
        wdog_d  = wdog_q;
        rv_d    = rv_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        re_d    = re_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    dvd_d   = req_dividend[int'(gnt_idx)*SIZE +: SIZE];
                    dvs_d   = req_divisor[int'(gnt_idx)*SIZE +: SIZE];
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + WDW'(1);
                if (div_done) begin
                    rq_d    = div_quotient;
                    rr_d    = div_remainder;
                    re_d    = div_error;
                    rv_d    = 1'b1;
                    state_d = RESP;
                end else if (int'(wdog_q) + 1 >= TIMEOUT) begin
                    // Divider never answered: force an error response.
                    rq_d    = '0;
                    rr_d    = '0;
                    re_d    = 1'b1;
                    rv_d    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any in-flight division.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            start_q <= 1'b0;
            wdog_q  <= '0;
            rv_q    <= 1'b0;
            rq_q    <= '0;
            rr_q    <= '0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            start_q <= start_d;
            wdog_q  <= wdog_d;
            rv_q    <= rv_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            re_q    <= re_d;
        end
    end

    assign div_start     = start_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign rsp_valid     = rv_q;
    assign rsp_id        = id_q;
    assign rsp_quotient  = rq_q;
    assign rsp_remainder = rr_q;
    assign rsp_error     = re_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed checks of the divider arbiter against a small
// behavioural divider (pulse or level done, optional hang).
module tb_div_arbiter;

    localparam int SIZE    = 32;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 255;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*SIZE-1:0] req_dividend;
    logic [NREQ*SIZE-1:0] req_divisor;
    logic                 div_start;
    logic [SIZE-1:0]      div_dividend;
    logic [SIZE-1:0]      div_divisor;
    logic                 div_done;
    logic                 div_error;
    logic [SIZE-1:0]      div_quotient;
    logic [SIZE-1:0]      div_remainder;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [SIZE-1:0]      rsp_quotient;
    logic [SIZE-1:0]      rsp_remainder;
    logic                 rsp_error;

    int checks   = 0;
    int failures = 0;

    bit              hang       = 1'b0;
    bit              level_mode = 1'b0;
    logic            busy;
    int              cnt;
    logic [SIZE-1:0] ma, mb;

    div_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_error(div_error),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_error(rsp_error)
    );

    always #5 clk = ~clk;

    // Behavioural divider: answers a few cycles after start; level mode holds done until next start.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0; cnt <= 0; ma <= '0; mb <= '0;
            div_done <= 1'b0; div_error <= 1'b0; div_quotient <= '0; div_remainder <= '0;
        end else if (div_start) begin
            busy <= 1'b1; cnt <= 3; div_done <= 1'b0;
            ma <= div_dividend; mb <= div_divisor;
        end else if (busy && !hang) begin
            if (cnt == 0) begin
                busy          <= 1'b0;
                div_done      <= 1'b1;
                div_error     <= (mb == 0);
                div_quotient  <= (mb == 0) ? '1 : ma / mb;
                div_remainder <= (mb == 0) ? ma : ma % mb;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (!level_mode) begin
            div_done <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise one request, wait for its grant, and drop it right after the transfer edge.
    task automatic send(input int id, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        bit ok;
        req_dividend[id*SIZE +: SIZE] = a;
        req_divisor[id*SIZE +: SIZE]  = b;
        req_valid[id] = 1'b1;
        #1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            if (req_ready[id]) ok = 1'b1;
            else tick();
        end
        if (!ok) chk("grant_timeout", 0, 1);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [SIZE-1:0] t_a [NREQ] = '{32'd100, 32'd1000, 32'd255, 32'd12345};
    logic [SIZE-1:0] t_b [NREQ] = '{32'd7, 32'd33, 32'd16, 32'd100};
    logic [SIZE-1:0] t_q [NREQ] = '{32'd14, 32'd30, 32'd15, 32'd123};
    logic [SIZE-1:0] t_r [NREQ] = '{32'd2, 32'd10, 32'd15, 32'd45};
    int              order [5]  = '{0, 1, 2, 3, 0};

    initial begin
        int cyc;
        reset        = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b0;
        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_req_ready", req_ready, 0);
        tick();
        reset = 1'b1;
        tick();

        // single request with start latency
        send(0, 32'd100, 32'd7);
        chk("t1_start_after_grant", div_start, 1);
        tick();
        chk("t1_start_one_cycle", div_start, 0);
        wait_rsp(cyc);
        chk("t1_id", rsp_id, 0);
        chk("t1_q", rsp_quotient, 14);
        chk("t1_r", rsp_remainder, 2);
        chk("t1_err", rsp_error, 0);
        ack();

        // all four held valid from reset, level-style done
        reset = 1'b0;
        tick();
        reset = 1'b1;
        level_mode = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*SIZE +: SIZE] = t_a[i];
            req_divisor[i*SIZE +: SIZE]  = t_b[i];
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(cyc);
            chk($sformatf("t2_id_%0d", k), rsp_id, order[k]);
            chk($sformatf("t2_q_%0d", k), rsp_quotient, t_q[order[k]]);
            chk($sformatf("t2_r_%0d", k), rsp_remainder, t_r[order[k]]);
            if (k == 4) begin
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                req_valid = '0;
            end else begin
                ack();
            end
        end
        level_mode = 1'b0;
        tick();

        // divide by zero passes the divider error through
        send(2, 32'd77, 32'd0);
        wait_rsp(cyc);
        chk("t3_id", rsp_id, 2);
        chk("t3_err", rsp_error, 1);
        ack();
        send(1, 32'd10, 32'd3);
        wait_rsp(cyc);
        chk("t3_next_id", rsp_id, 1);
        chk("t3_next_q", rsp_quotient, 3);
        chk("t3_next_r", rsp_remainder, 1);
        chk("t3_next_err", rsp_error, 0);
        ack();

        // divider never answers: watchdog forces an error
        hang = 1'b1;
        send(3, 32'd500, 32'd5);
        wait_rsp(cyc);
        chk("t4_err", rsp_error, 1);
        chk("t4_q", rsp_quotient, 0);
        chk("t4_r", rsp_remainder, 0);
        chk("t4_id", rsp_id, 3);
        chk("t4_wd_window", (cyc >= TIMEOUT && cyc <= TIMEOUT + 2), 1);
        ack();
        hang = 1'b0;

        // back in IDLE: next request served; then back-pressure on the response
        send(0, 32'd9, 32'd4);
        wait_rsp(cyc);
        req_dividend[1*SIZE +: SIZE] = 32'd50;
        req_divisor[1*SIZE +: SIZE]  = 32'd6;
        req_valid[1] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            chk($sformatf("t5_valid_%0d", n), rsp_valid, 1);
            chk($sformatf("t5_q_%0d", n), rsp_quotient, 2);
            chk($sformatf("t5_r_%0d", n), rsp_remainder, 1);
            chk($sformatf("t5_id_%0d", n), rsp_id, 0);
            chk($sformatf("t5_ready_%0d", n), req_ready, 0);
            tick();
        end
        ack();
        req_valid[1] = 1'b0;
        tick();

        // reset during WAIT clears everything immediately
        hang = 1'b1;
        send(2, 32'd1000, 32'd10);
        tick();
        tick();
        chk("t6_dvd_before", div_dividend, 1000);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_q", rsp_quotient, 0);
        chk("t6_rsp_r", rsp_remainder, 0);
        chk("t6_rsp_id", rsp_id, 0);
        chk("t6_dvd", div_dividend, 0);
        chk("t6_dvs", div_divisor, 0);
        chk("t6_start", div_start, 0);
        tick();
        reset = 1'b1;
        hang  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*SIZE +: SIZE] = t_a[i];
            req_divisor[i*SIZE +: SIZE]  = t_b[i];
        end
        req_valid = '1;
        #1;
        chk("t6_first_grant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp(cyc);
        chk("t6_id", rsp_id, 0);
        chk("t6_q", rsp_quotient, 14);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
